id_stage_piped: RTL and testbench

//  Parametrised MIPS decode stage plus ID/EX pipeline register. Reads the register file, sign-extends
//  the immediate, resolves BEQ/BNE/J/JAL in ID, detects load-use and branch-operand hazards, and

---
 rtl/id_stage_piped.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_id_stage_piped.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_piped.sv
// id_stage_piped: MIPS decode stage plus the ID/EX pipeline register.
// It reads the register file and sign-extends the immediate. BEQ, BNE, J
// and JAL are resolved in ID. Load-use and branch-operand hazards are
// detected here, and the decoded operands are registered for EX.
//
// Optional feature: define ID_BRANCH_FWD_EN to forward mem_data into the
// branch comparator. Without it, a branch operand produced by the EX/MEM
// instruction stalls the branch for one cycle.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   id_valid           IF/ID holds a real instruction
//   instruction, pc    instruction word and its PC+4
//   wb_we/addr/data    register-file write port (write-back stage)
//   mem_we/addr/data   EX/MEM destination info (mem_data used for forwarding)
//   ex_hold            downstream stall: freeze ID/EX
//   stall, flush       back-pressure and squash towards IF
//   pc_src             0 PC+4, 1 branch target, 2 jump target
//   branch_addr        pc + (sext(imm) << 2)
//   j_addr             {pc[XLEN-1:28], target, 2'b00}
//   ex_*               registered ID/EX payload
module id_stage_piped #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    localparam int unsigned RAW  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic            wb_we,
    input  logic [RAW-1:0]  wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            mem_we,
    input  logic [RAW-1:0]  mem_addr,
    input  logic [XLEN-1:0] mem_data,
    input  logic            ex_hold,
    output logic            stall,
    output logic            flush,
    output logic [1:0]      pc_src,
    output logic [XLEN-1:0] branch_addr,
    output logic [XLEN-1:0] j_addr,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_read1,
    output logic [XLEN-1:0] ex_read2,
    output logic [XLEN-1:0] ex_imm,
    output logic [RAW-1:0]  ex_rs,
    output logic [RAW-1:0]  ex_rt,
    output logic [RAW-1:0]  ex_rd,
    output logic [5:0]      ex_opcode,
    output logic [5:0]      ex_funct,
    output logic [RAW-1:0]  ex_dest,
    output logic            ex_reg_write,
    output logic            ex_mem_read
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Instruction fields
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [RAW-1:0]  rs;
    logic [RAW-1:0]  rt;
    logic [RAW-1:0]  rd;
    logic [15:0]     imm16;
    logic [XLEN-1:0] sext_imm;

    assign opcode   = instruction[31:26];
    assign funct    = instruction[5:0];
    assign rs       = RAW'(instruction[25:21]);
    assign rt       = RAW'(instruction[20:16]);
    assign rd       = RAW'(instruction[15:11]);
    assign imm16    = instruction[15:0];
    assign sext_imm = {{(XLEN-16){imm16[15]}}, imm16};

    // Instruction class decode
    logic is_rtype;
    logic is_branch;
    logic is_jump;
    logic writes_reg;
    logic [RAW-1:0] dest;

    always_comb begin
        is_rtype   = (opcode == OP_RTYPE) && (funct != FN_JR);
        is_branch  = (opcode == OP_BEQ) || (opcode == OP_BNE);
        is_jump    = (opcode == OP_J) || (opcode == OP_JAL);
        writes_reg = is_rtype || (opcode == OP_LW) || (opcode == OP_ADDI) ||
                     (opcode == OP_SLTI) || (opcode == OP_ANDI) ||
                     (opcode == OP_ORI) || (opcode == OP_JAL);
        if (opcode == OP_JAL) begin
            dest = RAW'(31);
        end else if (opcode == OP_RTYPE) begin
            dest = rd;
        end else begin
            dest = rt;
        end
    end

    // Register file; not cleared by reset, register 0 is never written
    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (wb_we && (wb_addr != '0)) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Combinational reads with write-before-read bypass
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;

    always_comb begin
        rs_val = '0;
        if (rs != '0) begin
            rs_val = (wb_we && (wb_addr == rs)) ? wb_data : regs_q[rs];
        end
    end

    always_comb begin
        rt_val = '0;
        if (rt != '0) begin
            rt_val = (wb_we && (wb_addr == rt)) ? wb_data : regs_q[rt];
        end
    end

    // Registered ID/EX payload
    logic            ex_valid_q,     ex_valid_d;
    logic [XLEN-1:0] ex_read1_q,     ex_read1_d;
    logic [XLEN-1:0] ex_read2_q,     ex_read2_d;
    logic [XLEN-1:0] ex_imm_q,       ex_imm_d;
    logic [RAW-1:0]  ex_rs_q,        ex_rs_d;
    logic [RAW-1:0]  ex_rt_q,        ex_rt_d;
    logic [RAW-1:0]  ex_rd_q,        ex_rd_d;
    logic [5:0]      ex_opcode_q,    ex_opcode_d;
    logic [5:0]      ex_funct_q,     ex_funct_d;
    logic [RAW-1:0]  ex_dest_q,      ex_dest_d;
    logic            ex_reg_write_q, ex_reg_write_d;
    logic            ex_mem_read_q,  ex_mem_read_d;

    // Hazard detection; register 0 never creates a dependency
    logic ex_hit;
    logic mem_hit_rs;
    logic mem_hit_rt;
    logic load_use;
    logic br_ex_hazard;
    logic br_mem_stall;
    logic hazard;
    logic [XLEN-1:0] cmp_a;
    logic [XLEN-1:0] cmp_b;

    always_comb begin
        ex_hit = (ex_dest_q != '0) && ((ex_dest_q == rs) || (ex_dest_q == rt));
        mem_hit_rs = mem_we && (mem_addr != '0) && (mem_addr == rs);
        mem_hit_rt = mem_we && (mem_addr != '0) && (mem_addr == rt);
        load_use = ex_valid_q && ex_mem_read_q && ex_hit;
        br_ex_hazard = is_branch && ex_valid_q && ex_reg_write_q && ex_hit;
`ifdef ID_BRANCH_FWD_EN
        // EX/MEM result is forwarded into the comparator instead of stalling
        br_mem_stall = 1'b0;
        cmp_a = mem_hit_rs ? mem_data : rs_val;
        cmp_b = mem_hit_rt ? mem_data : rt_val;
`else
        br_mem_stall = is_branch && (mem_hit_rs || mem_hit_rt);
        cmp_a = rs_val;
        cmp_b = rt_val;
`endif
        hazard = id_valid && (load_use || br_ex_hazard || br_mem_stall);
    end

`ifndef ID_BRANCH_FWD_EN
    // mem_data only feeds the comparator when forwarding is built in
    logic unused_mem_data;
    assign unused_mem_data = ^mem_data;
`endif

    // Branch/jump resolution and IF control
    logic resolve_en;
    logic br_taken;

    always_comb begin
        resolve_en  = id_valid && !hazard && !ex_hold;
        br_taken    = ((opcode == OP_BEQ) && (cmp_a == cmp_b)) ||
                      ((opcode == OP_BNE) && (cmp_a != cmp_b));
        stall       = ex_hold || hazard;
        flush       = 1'b0;
        pc_src      = 2'd0;
        branch_addr = pc + {sext_imm[XLEN-3:0], 2'b00};
        j_addr      = {pc[XLEN-1:28], instruction[25:0], 2'b00};
        if (resolve_en && is_jump) begin
            flush  = 1'b1;
            pc_src = 2'd2;
        end else if (resolve_en && br_taken) begin
            flush  = 1'b1;
            pc_src = 2'd1;
        end
    end

    // ID/EX next state: hold > bubble > load
    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_read1_d     = ex_read1_q;
        ex_read2_d     = ex_read2_q;
        ex_imm_d       = ex_imm_q;
        ex_rs_d        = ex_rs_q;
        ex_rt_d        = ex_rt_q;
        ex_rd_d        = ex_rd_q;
        ex_opcode_d    = ex_opcode_q;
        ex_funct_d     = ex_funct_q;
        ex_dest_d      = ex_dest_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;
        if (ex_hold) begin
            // keep everything
        end else if (hazard) begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
        end else begin
            ex_valid_d     = id_valid;
            ex_read1_d     = rs_val;
            ex_read2_d     = rt_val;
            ex_imm_d       = sext_imm;
            ex_rs_d        = rs;
            ex_rt_d        = rt;
            ex_rd_d        = rd;
            ex_opcode_d    = opcode;
            ex_funct_d     = funct;
            ex_dest_d      = dest;
            ex_reg_write_d = id_valid && writes_reg;
            ex_mem_read_d  = id_valid && (opcode == OP_LW);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_read1_q     <= '0;
            ex_read2_q     <= '0;
            ex_imm_q       <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_rd_q        <= '0;
            ex_opcode_q    <= '0;
            ex_funct_q     <= '0;
            ex_dest_q      <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_read1_q     <= ex_read1_d;
            ex_read2_q     <= ex_read2_d;
            ex_imm_q       <= ex_imm_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_rd_q        <= ex_rd_d;
            ex_opcode_q    <= ex_opcode_d;
            ex_funct_q     <= ex_funct_d;
            ex_dest_q      <= ex_dest_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_read1     = ex_read1_q;
    assign ex_read2     = ex_read2_q;
    assign ex_imm       = ex_imm_q;
    assign ex_rs        = ex_rs_q;
    assign ex_rt        = ex_rt_q;
    assign ex_rd        = ex_rd_q;
    assign ex_opcode    = ex_opcode_q;
    assign ex_funct     = ex_funct_q;
    assign ex_dest      = ex_dest_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;

endmodule

// File: tb/tb_id_stage_piped.sv
// Directed self-checking bench for id_stage_piped (XLEN=32, NREGS=32).
module tb_id_stage_piped;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        ex_hold;
    logic        stall;
    logic        flush;
    logic [1:0]  pc_src;
    logic [31:0] branch_addr;
    logic [31:0] j_addr;
    logic        ex_valid;
    logic [31:0] ex_read1;
    logic [31:0] ex_read2;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [5:0]  ex_opcode;
    logic [5:0]  ex_funct;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_mem_read;

    int checks = 0;
    int errors = 0;

    id_stage_piped #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .instruction(instruction), .pc(pc),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .ex_hold(ex_hold),
        .stall(stall), .flush(flush), .pc_src(pc_src),
        .branch_addr(branch_addr), .j_addr(j_addr),
        .ex_valid(ex_valid), .ex_read1(ex_read1), .ex_read2(ex_read2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
        .ex_funct(ex_funct), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; instruction = '0; pc = '0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        mem_we = 1'b0; mem_addr = '0; mem_data = '0; ex_hold = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_ex_imm", 64'(ex_imm), 64'd0);
        check("rst_ex_dest", 64'(ex_dest), 64'd0);
        check("rst_ex_opcode", 64'(ex_opcode), 64'd0);
        check("rst_ex_read1", 64'(ex_read1), 64'd0);

        // ADDI r2,r0,5 lands in EX one cycle later
        rst = 1'b0; id_valid = 1'b1; pc = 32'h4;
        instruction = enc_i(6'h08, 5'd0, 5'd2, 16'd5);
        #1;
        check("addi_stall", 64'(stall), 64'd0);
        check("addi_flush", 64'(flush), 64'd0);
        tick();
        check("addi_ex_valid", 64'(ex_valid), 64'd1);
        check("addi_ex_imm", 64'(ex_imm), 64'd5);
        check("addi_ex_dest", 64'(ex_dest), 64'd2);
        check("addi_ex_reg_write", 64'(ex_reg_write), 64'd1);
        check("addi_ex_read1", 64'(ex_read1), 64'd0);

        // Preload registers with nothing in ID
        id_valid = 1'b0;
        wb_write(5'd1, 32'h7);
        wb_write(5'd6, 32'h11);
        wb_write(5'd7, 32'h55);
        wb_write(5'd4, 32'h40);
        check("idle_bubble", 64'(ex_valid), 64'd0);
        check("idle_no_write", 64'(ex_reg_write), 64'd0);

        // Same-cycle write-back bypass: ADD r8,r3,r1 while writing r3
        id_valid = 1'b1; instruction = enc_r(5'd3, 5'd1, 5'd8, 6'h20);
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD;
        tick();
        check("byp_read1", 64'(ex_read1), 64'hDEAD);
        check("byp_read2", 64'(ex_read2), 64'h7);
        check("byp_dest", 64'(ex_dest), 64'd8);
        check("byp_funct", 64'(ex_funct), 64'h20);

        // Write to r0 is ignored; r3 now holds 0xDEAD
        wb_addr = 5'd0; wb_data = 32'hBEEF;
        instruction = enc_r(5'd0, 5'd3, 5'd9, 6'h20);
        tick();
        wb_we = 1'b0;
        check("r0_read", 64'(ex_read1), 64'd0);
        check("r3_stored", 64'(ex_read2), 64'hDEAD);

        // Load-use: LW r4,0(r1) then ADD r5,r4,r1
        instruction = enc_i(6'h23, 5'd1, 5'd4, 16'd0);
        tick();
        check("lw_mem_read", 64'(ex_mem_read), 64'd1);
        check("lw_dest", 64'(ex_dest), 64'd4);
        instruction = enc_r(5'd4, 5'd1, 5'd5, 6'h20);
        #1;
        check("lu_stall", 64'(stall), 64'd1);
        tick();
        check("lu_bubble_valid", 64'(ex_valid), 64'd0);
        check("lu_bubble_write", 64'(ex_reg_write), 64'd0);
        check("lu_released", 64'(stall), 64'd0);
        tick();
        check("lu_add_valid", 64'(ex_valid), 64'd1);
        check("lu_add_dest", 64'(ex_dest), 64'd5);
        check("lu_add_read1", 64'(ex_read1), 64'h40);

        // BEQ r1,r1,+3 at pc 0x100 is taken
        pc = 32'h100; instruction = enc_i(6'h04, 5'd1, 5'd1, 16'd3);
        #1;
        check("beq_pc_src", 64'(pc_src), 64'd1);
        check("beq_flush", 64'(flush), 64'd1);
        check("beq_target", 64'(branch_addr), 64'h10C);
        check("beq_stall", 64'(stall), 64'd0);
        tick();
        check("beq_flush_1cyc", 64'(flush), 64'd1);
        instruction = enc_i(6'h05, 5'd1, 5'd1, 16'd3);
        #1;
        check("bne_eq_pc_src", 64'(pc_src), 64'd0);
        check("bne_eq_flush", 64'(flush), 64'd0);
        tick();

        // BNE r1,r6,-1: taken, negative offset
        instruction = enc_i(6'h05, 5'd1, 5'd6, 16'hFFFF);
        #1;
        check("bne_neg_pc_src", 64'(pc_src), 64'd1);
        check("bne_neg_target", 64'(branch_addr), 64'hFC);
        tick();

        // Branch EX hazard: ADDI r10 then BEQ r10,r1
        instruction = enc_i(6'h08, 5'd0, 5'd10, 16'd1);
        tick();
        instruction = enc_i(6'h04, 5'd10, 5'd1, 16'd2);
        #1;
        check("brex_stall", 64'(stall), 64'd1);
        check("brex_flush", 64'(flush), 64'd0);
        tick();
        check("brex_bubble", 64'(ex_valid), 64'd0);

        // J 0x40 at pc 0x1000_0004
        pc = 32'h1000_0004; instruction = enc_j(6'h02, 26'h40);
        #1;
        check("j_pc_src", 64'(pc_src), 64'd2);
        check("j_flush", 64'(flush), 64'd1);
        check("j_addr", 64'(j_addr), 64'h1000_0100);
        tick();
        check("j_ex_opcode", 64'(ex_opcode), 64'h02);

        // ex_hold with JAL in ID: nothing resolves, EX frozen
        ex_hold = 1'b1; instruction = enc_j(6'h03, 26'h80);
        #1;
        check("hold_stall", 64'(stall), 64'd1);
        check("hold_flush", 64'(flush), 64'd0);
        check("hold_pc_src", 64'(pc_src), 64'd0);
        tick();
        check("hold_opcode", 64'(ex_opcode), 64'h02);
        check("hold_imm", 64'(ex_imm), 64'h40);
        check("hold_valid", 64'(ex_valid), 64'd1);
        ex_hold = 1'b0;
        #1;
        check("jal_pc_src", 64'(pc_src), 64'd2);
        check("jal_addr", 64'(j_addr), 64'h1000_0200);
        tick();
        check("jal_dest", 64'(ex_dest), 64'd31);
        check("jal_write", 64'(ex_reg_write), 64'd1);

        // Branch MEM hazard: BEQ r6,r7 with EX/MEM writing r6 = r7 value
        pc = 32'h200; instruction = enc_i(6'h04, 5'd6, 5'd7, 16'd1);
        mem_we = 1'b1; mem_addr = 5'd6; mem_data = 32'h55;
        #1;
`ifdef ID_BRANCH_FWD_EN
        check("mem_fwd_stall", 64'(stall), 64'd0);
        check("mem_fwd_pc_src", 64'(pc_src), 64'd1);
        check("mem_fwd_target", 64'(branch_addr), 64'h204);
        tick();
        check("mem_fwd_valid", 64'(ex_valid), 64'd1);
`else
        check("mem_stall", 64'(stall), 64'd1);
        check("mem_stall_pc_src", 64'(pc_src), 64'd0);
        check("mem_stall_flush", 64'(flush), 64'd0);
        tick();
        check("mem_stall_bubble", 64'(ex_valid), 64'd0);
`endif
        // Without the match the regfile values differ: not taken
        mem_we = 1'b0;
        #1;
        check("mem_gone_stall", 64'(stall), 64'd0);
        check("mem_gone_pc_src", 64'(pc_src), 64'd0);
        tick();
        check("beq_nt_valid", 64'(ex_valid), 64'd1);

        // Reset mid-run clears ID/EX
        rst = 1'b1;
        tick();
        check("rst2_valid", 64'(ex_valid), 64'd0);
        check("rst2_write", 64'(ex_reg_write), 64'd0);
        check("rst2_imm", 64'(ex_imm), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
